// File: rtl/rll_key_pkg.sv
// Shared types and defaults for the RLL key-load controller.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package rll_key_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PAR,
    SETTLE,
    READY,
    ERROR
  } state_t;

  localparam int KEY_W_DEF  = 16;
  localparam int SETTLE_DEF = 4;

  // Counter must index every key bit and also count the settle window.
  function automatic int cnt_width(input int key_w, input int settle_cyc);
    int span;
    span = (key_w > settle_cyc + 1) ? key_w : settle_cyc + 1;
    return (span > 1) ? $clog2(span) : 1;
  endfunction

endpackage

// File: rtl/rll_key_shreg.sv
// Shadow register holding the key while it is shifted in; exposes even parity.
// Latency: a bit written this cycle is visible in shadow the next cycle.
// Backpressure: none; writes whenever wr_en is high, clr has priority.
module rll_key_shreg
  import rll_key_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_bit,
  output logic [KEY_W-1:0] shadow,
  output logic             par
);

  // Indexed bit write; a clear always wins over a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (clr) begin
      shadow <= '0;
    end else if (wr_en) begin
      shadow[wr_idx] <= wr_bit;
    end
  end

  // Even-parity bit over the captured key.
  assign par = ^shadow;

endmodule

// File: rtl/rll_key_load_ctrl.sv
// Receives a serial key, commits it to the locked core in one cycle, then flags key_loaded after a settle window.
// Latency: start -> first beat 1 cycle; last beat -> key_loaded SETTLE_CYC+2 cycles (+1 with parity).
// Backpressure: key_ready is high only while collecting key (and parity) bits; optional parity via RLL_KEY_PARITY_EN.
module rll_key_load_ctrl
  import rll_key_pkg::*;
#(
  parameter int KEY_W      = KEY_W_DEF,
  parameter int SETTLE_CYC = SETTLE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             zeroize,
  input  logic             key_bit,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_loaded,
  output logic             busy,
  output logic             err
);

  localparam int CNT_W = cnt_width(KEY_W, SETTLE_CYC);
  localparam int IDX_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYC);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             commit_pend;
  logic             beat;
  logic             start_ok;
  logic [KEY_W-1:0] shadow;
  logic             shadow_par;

  assign beat     = key_valid && key_ready;
  assign start_ok = start && (state == IDLE || state == READY || state == ERROR);

  rll_key_shreg #(
    .KEY_W (KEY_W),
    .IDX_W (IDX_W)
  ) u_shreg (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (zeroize || start_ok),
    .wr_en  (!zeroize && state == LOAD && beat),
    .wr_idx (cnt[IDX_W-1:0]),
    .wr_bit (key_bit),
    .shadow (shadow),
    .par    (shadow_par)
  );

`ifndef RLL_KEY_PARITY_EN
  logic unused_par;
  assign unused_par = shadow_par;
  assign err        = 1'b0;
`endif

  // Load sequencer: collect bits, commit in one cycle, settle, then hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      commit_pend <= 1'b0;
      key_ready   <= 1'b0;
      key_out     <= '0;
      key_loaded  <= 1'b0;
      busy        <= 1'b0;
`ifdef RLL_KEY_PARITY_EN
      err         <= 1'b0;
`endif
    end else if (zeroize) begin
      state       <= IDLE;
      cnt         <= '0;
      commit_pend <= 1'b0;
      key_ready   <= 1'b0;
      key_out     <= '0;
      key_loaded  <= 1'b0;
      busy        <= 1'b0;
`ifdef RLL_KEY_PARITY_EN
      err         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, READY, ERROR: begin
          // The old key is pulled from the core before any new bit arrives.
          if (start) begin
            state      <= LOAD;
            cnt        <= '0;
            key_ready  <= 1'b1;
            busy       <= 1'b1;
            key_out    <= '0;
            key_loaded <= 1'b0;
`ifdef RLL_KEY_PARITY_EN
            err        <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (beat) begin
            if (cnt == LAST_IDX) begin
              cnt <= '0;
`ifdef RLL_KEY_PARITY_EN
              state <= PAR;
`else
              state       <= SETTLE;
              key_ready   <= 1'b0;
              commit_pend <= 1'b1;
`endif
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
`ifdef RLL_KEY_PARITY_EN
        PAR: begin
          if (beat) begin
            key_ready <= 1'b0;
            if (key_bit == shadow_par) begin
              state       <= SETTLE;
              commit_pend <= 1'b1;
            end else begin
              state <= ERROR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end
          end
        end
`endif
        SETTLE: begin
          // First cycle commits the full key; the window is counted afterwards.
          if (commit_pend) begin
            key_out     <= shadow;
            commit_pend <= 1'b0;
          end else if (cnt == SETTLE_END) begin
            state      <= READY;
            cnt        <= '0;
            key_loaded <= 1'b1;
            busy       <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rll_key_load_ctrl.sv
// Randomized bench for rll_key_load_ctrl against a timestamp-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_rll_key_load_ctrl;

  localparam int KEY_W  = 16;
  localparam int SETTLE = 4;
`ifdef RLL_KEY_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             zeroize;
  logic             key_bit;
  logic             key_valid;
  logic             key_ready;
  logic [KEY_W-1:0] key_out;
  logic             key_loaded;
  logic             busy;
  logic             err;

  always #5 clk = ~clk;

  rll_key_load_ctrl #(
    .KEY_W      (KEY_W),
    .SETTLE_CYC (SETTLE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .zeroize    (zeroize),
    .key_bit    (key_bit),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_out    (key_out),
    .key_loaded (key_loaded),
    .busy       (busy),
    .err        (err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: which phase we are in plus the edge of the final accepted beat.
  bit               m_loading;
  bit               m_par_wait;
  bit               m_err;
  int               m_cnt;
  logic [KEY_W-1:0] m_acc;
  logic [KEY_W-1:0] m_key;
  int               last_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
  endtask

  task automatic model_idle();
    m_loading  = 1'b0;
    m_par_wait = 1'b0;
    m_err      = 1'b0;
    m_cnt      = 0;
    m_acc      = '0;
    last_n     = -1;
  endtask

  function automatic bit model_busy();
    return m_loading || m_par_wait || (last_n >= 0 && (cyc - last_n) < SETTLE + 2);
  endfunction

  // Apply the effect of the edge just taken, using the inputs held across it.
  task automatic model_edge();
    bit was_busy;
    was_busy = model_busy();
    cyc++;
    if (!rst_n || zeroize) begin
      model_idle();
    end else if (start && !was_busy) begin
      model_idle();
      m_loading = 1'b1;
    end else if (m_loading && key_valid) begin
      m_acc[m_cnt] = key_bit;
      m_cnt++;
      if (m_cnt == KEY_W) begin
        m_loading = 1'b0;
        if (PAR_EN != 0) begin
          m_par_wait = 1'b1;
        end else begin
          m_key  = m_acc;
          last_n = cyc;
        end
      end
    end else if (m_par_wait && key_valid) begin
      m_par_wait = 1'b0;
      if (key_bit == ^m_acc) begin
        m_key  = m_acc;
        last_n = cyc;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [KEY_W-1:0] e_out;
    logic             e_loaded;
    logic             e_busy;
    logic             e_ready;
    int               d;
    e_ready = m_loading || m_par_wait;
    if (last_n >= 0) begin
      d        = cyc - last_n;
      e_out    = (d >= 1) ? m_key : '0;
      e_loaded = (d >= SETTLE + 2);
      e_busy   = (d < SETTLE + 2);
    end else begin
      e_out    = '0;
      e_loaded = 1'b0;
      e_busy   = e_ready;
    end
    check("key_out", 32'(key_out), 32'(e_out));
    check("key_loaded", 32'(key_loaded), 32'(e_loaded));
    check("busy", 32'(busy), 32'(e_busy));
    check("key_ready", 32'(key_ready), 32'(e_ready));
    check("err", 32'(err), 32'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Shift a key in LSB first; optional idle gaps, spurious starts and a bad parity bit.
  task automatic send_key(input logic [KEY_W-1:0] key, input bit gaps, input bit noise, input bit par_flip);
    int idx;
    int guard;
    idx   = 0;
    guard = 0;
    while (idx < KEY_W + PAR_EN && guard < 400) begin
      key_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!key_valid) key_bit = 1'($urandom_range(0, 1));
      else if (idx < KEY_W) key_bit = key[idx];
      else key_bit = (^key) ^ par_flip;
      start = noise ? ($urandom_range(0, 5) == 0) : 1'b0;
      step();
      if (key_valid) idx++;
      guard++;
    end
    key_valid = 1'b0;
    start     = 1'b0;
    if (guard >= 400) check("load_timeout", 32'(idx), 32'(KEY_W + PAR_EN));
  endtask

  initial begin
    logic [KEY_W-1:0] k;
    rst_n     = 1'b0;
    start     = 1'b0;
    zeroize   = 1'b0;
    key_bit   = 1'b0;
    key_valid = 1'b0;
    model_idle();
    m_key = '0;

    // Reset state
    run(3);
    #1 rst_n = 1'b1;
    run(2);

    // 1: plain load of 0xA5C3, key_loaded SETTLE+2 cycles after the last beat
    pulse_start();
    send_key(16'hA5C3, 1'b0, 1'b0, 1'b0);
    run(SETTLE + 3);
    check("t1_key", 32'(key_out), 32'h0000A5C3);
    check("t1_loaded", 32'(key_loaded), 32'h1);

    // 2: gapped beats with ignored starts while busy
    pulse_start();
    send_key(16'hA5C3, 1'b1, 1'b1, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    run(SETTLE + 3);
    check("t2_key", 32'(key_out), 32'h0000A5C3);

    // 3: zeroize on beat 8, then load 0x0001
    pulse_start();
    k = 16'hBEEF;
    for (int i = 0; i < 7; i++) begin
      key_valid = 1'b1;
      key_bit   = k[i];
      step();
    end
    key_valid = 1'b1;
    key_bit   = k[7];
    zeroize   = 1'b1;
    step();
    zeroize   = 1'b0;
    key_valid = 1'b0;
    run(2);
    pulse_start();
    send_key(16'h0001, 1'b0, 1'b0, 1'b0);
    run(SETTLE + 3);
    check("t3_key", 32'(key_out), 32'h00000001);

    // 4: restart from READY with 0xFFFF
    pulse_start();
    check("t4_cleared", 32'(key_out), 32'h0);
    send_key(16'hFFFF, 1'b1, 1'b0, 1'b0);
    run(SETTLE + 3);
    check("t4_key", 32'(key_out), 32'h0000FFFF);

`ifdef RLL_KEY_PARITY_EN
    // 5: parity mismatch then a good reload
    pulse_start();
    send_key(16'h0003, 1'b0, 1'b0, 1'b1);
    run(3);
    check("t5_err", 32'(err), 32'h1);
    check("t5_key0", 32'(key_out), 32'h0);
    pulse_start();
    send_key(16'h0003, 1'b0, 1'b0, 1'b0);
    run(SETTLE + 3);
    check("t5_loaded", 32'(key_loaded), 32'h1);
    check("t5_noerr", 32'(err), 32'h0);
`endif

    // Random loads, with occasional zeroize while READY
    for (int t = 0; t < 8; t++) begin
      pulse_start();
      send_key(KEY_W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               (PAR_EN != 0) && ($urandom_range(0, 3) == 0));
      run(SETTLE + 2 + $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin
        zeroize = 1'b1;
        step();
        zeroize = 1'b0;
      end
    end

    // 6: async reset during SETTLE
    pulse_start();
    send_key(16'h5A5A, 1'b0, 1'b0, 1'b0);
    run(2);
    rst_n = 1'b0;
    #2;
    check("t6_key_out", 32'(key_out), 32'h0);
    check("t6_loaded", 32'(key_loaded), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_ready", 32'(key_ready), 32'h0);
    check("t6_err", 32'(err), 32'h0);
    model_idle();
    run(2);
    rst_n = 1'b1;
    run(2);
    pulse_start();
    check("t6_ready_after_start", 32'(key_ready), 32'h1);
    send_key(16'h1234, 1'b0, 1'b0, 1'b0);
    run(SETTLE + 3);
    check("t6_key", 32'(key_out), 32'h00001234);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
